// File: rtl/fetch_queue_pkg.sv
// Shared parameters for the fetch queue: default widths, front-end opcode
// constants, the fetch FSM state type and a counter-width helper.
package fetch_queue_pkg;

  // Default widths of the fetch path.
  localparam int unsigned FQ_PC_WIDTH_DEFAULT    = 4;
  localparam int unsigned FQ_INSTR_WIDTH_DEFAULT = 16;
  localparam int unsigned FQ_DEPTH_DEFAULT       = 4;

  // Opcode field (top nibble of an instruction word) used by the front end.
  localparam int unsigned FQ_OPCODE_WIDTH = 4;
  localparam logic [FQ_OPCODE_WIDTH-1:0] OPC_NOP  = 4'h0;
  localparam logic [FQ_OPCODE_WIDTH-1:0] OPC_ADD  = 4'h1;
  localparam logic [FQ_OPCODE_WIDTH-1:0] OPC_SUB  = 4'h2;
  localparam logic [FQ_OPCODE_WIDTH-1:0] OPC_LOAD = 4'h3;
  localparam logic [FQ_OPCODE_WIDTH-1:0] OPC_STOR = 4'h4;
  localparam logic [FQ_OPCODE_WIDTH-1:0] OPC_JMP  = 4'h8;
  localparam logic [FQ_OPCODE_WIDTH-1:0] OPC_BEQ  = 4'h9;

  // Fetch FSM: FETCH issues reads, FLUSH drops one cycle after a redirect.
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } fq_state_e;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int unsigned fq_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO holding fetched {instruction, pc} entries.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   flush           synchronous empty (wins over push/pop)
//   push, push_data write one entry at the tail
//   pop             remove the head entry
//   head_data       current head entry (stale when empty)
//   empty           no entries held
//   count           number of entries held (0..DEPTH)
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head_data,
  output logic               empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_c;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full_c    = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign head_data = mem_q[rd_ptr_q];

  // Guard against overflow/underflow; a pop frees the slot a full push needs.
  assign pop_ok_c  = pop && !empty;
  assign push_ok_c = push && (!full_c || pop_ok_c);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok_c) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok_c, pop_ok_c})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential reads to a synchronous
// instruction memory, buffers returned words with their addresses and hands
// them to the decoder; a redirect flushes everything and restarts fetch.
// Ports:
//   clock, resetN       clock, async active-low reset
//   memAddress          read address (= fetch pc)
//   memReadEnable       read strobe; memData valid one cycle later
//   memData             instruction memory read data
//   redirectValid/Pc    flush and restart fetch at redirectPc
//   instructionValid    queue head valid
//   instruction/Pc      head word and its address (0 when empty)
//   instructionReady    consumer takes the head when valid
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned PC_WIDTH          = FQ_PC_WIDTH_DEFAULT,
  parameter int unsigned INSTRUCTION_WIDTH = FQ_INSTR_WIDTH_DEFAULT,
  parameter int unsigned QUEUE_DEPTH       = FQ_DEPTH_DEFAULT
) (
  input  logic                         clock,
  input  logic                         resetN,
  output logic [PC_WIDTH-1:0]          memAddress,
  output logic                         memReadEnable,
  input  logic [INSTRUCTION_WIDTH-1:0] memData,
  input  logic                         redirectValid,
  input  logic [PC_WIDTH-1:0]          redirectPc,
  output logic                         instructionValid,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]          instructionPc,
  input  logic                         instructionReady
);

  localparam int unsigned CNT_W   = fq_cnt_width(QUEUE_DEPTH);
  localparam int unsigned ENTRY_W = INSTRUCTION_WIDTH + PC_WIDTH;

  fq_state_e             state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  in_flight_q, in_flight_d;
  logic [PC_WIDTH-1:0]   in_flight_pc_q, in_flight_pc_d;

  logic [CNT_W-1:0]             fifo_count;
  logic                         fifo_empty;
  logic [ENTRY_W-1:0]           fifo_head;
  logic [INSTRUCTION_WIDTH-1:0] head_instr;
  logic [PC_WIDTH-1:0]          head_pc;

  logic credit_ok_c;
  logic issue_c;
  logic push_c;
  logic pop_c;

  // Credits cover queued plus in-flight entries; a same-cycle pop is not
  // counted, so the FIFO can never be asked to overflow.
  assign credit_ok_c = (fifo_count + CNT_W'(in_flight_q)) < CNT_W'(QUEUE_DEPTH);
  assign issue_c     = (state_q == ST_FETCH) && !redirectValid && credit_ok_c;

  // Flops are already held in reset; only the strobe needs explicit masking.
  assign memReadEnable = issue_c && resetN;
  assign memAddress    = pc_q;

  // A return is only live in FETCH; redirect discards it (in FLUSH the
  // in-flight flag is already clear).
  assign push_c = in_flight_q && !redirectValid;
  assign pop_c  = instructionValid && instructionReady;

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (resetN),
    .flush     (redirectValid),
    .push      (push_c),
    .push_data ({memData, in_flight_pc_q}),
    .pop       (pop_c),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {head_instr, head_pc} = fifo_head;
  assign instructionValid      = !fifo_empty;
  assign instruction           = fifo_empty ? '0 : head_instr;
  assign instructionPc         = fifo_empty ? '0 : head_pc;

  // Next-state: redirect wins in any state; otherwise fetch sequentially.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    in_flight_d    = 1'b0;
    in_flight_pc_d = in_flight_pc_q;
    case (state_q)
      ST_FETCH: begin
        if (redirectValid) begin
          state_d = ST_FLUSH;
          pc_d    = redirectPc;
        end else if (issue_c) begin
          in_flight_d    = 1'b1;
          in_flight_pc_d = pc_q;
          pc_d           = pc_q + PC_WIDTH'(1);
        end
      end
      ST_FLUSH: begin
        if (redirectValid) begin
          pc_d = redirectPc;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q        <= ST_FETCH;
      pc_q           <= '0;
      in_flight_q    <= 1'b0;
      in_flight_pc_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      in_flight_q    <= in_flight_d;
      in_flight_pc_q <= in_flight_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based model.
module tb_fetch_queue;

  localparam int unsigned PCW   = 4;
  localparam int unsigned IW    = 16;
  localparam int unsigned DEPTH = 4;

  logic            clock = 1'b0;
  logic            resetN;
  logic [PCW-1:0]  memAddress;
  logic            memReadEnable;
  logic [IW-1:0]   memData;
  logic            redirectValid;
  logic [PCW-1:0]  redirectPc;
  logic            instructionValid;
  logic [IW-1:0]   instruction;
  logic [PCW-1:0]  instructionPc;
  logic            instructionReady;

  always #5 clock = ~clock;

  fetch_queue #(
    .PC_WIDTH          (PCW),
    .INSTRUCTION_WIDTH (IW),
    .QUEUE_DEPTH       (DEPTH)
  ) dut (
    .clock            (clock),
    .resetN           (resetN),
    .memAddress       (memAddress),
    .memReadEnable    (memReadEnable),
    .memData          (memData),
    .redirectValid    (redirectValid),
    .redirectPc       (redirectPc),
    .instructionValid (instructionValid),
    .instruction      (instruction),
    .instructionPc    (instructionPc),
    .instructionReady (instructionReady)
  );

  // Synchronous instruction memory.
  logic [IW-1:0] mem [16];
  always @(posedge clock) if (memReadEnable) memData <= mem[memAddress];

  // Reference model: queue of {word, pc}, next fetch address, one pending return.
  logic [IW+PCW-1:0] mq[$];
  int                m_fpc;
  bit                m_infl;
  logic [IW+PCW-1:0] m_infl_ent;
  bit                m_flush;

  int checks = 0;
  int errors = 0;

  logic           obs_rden;
  logic [PCW-1:0] obs_addr;
  logic           obs_valid;
  logic [IW-1:0]  obs_instr;
  logic [PCW-1:0] obs_ipc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc   = 0;
    m_infl  = 0;
    m_flush = 0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model with the
  // inputs held this cycle, then return 1 time unit after the rising edge.
  task automatic step();
    bit                e_rden;
    logic [IW+PCW-1:0] head;
    @(negedge clock);
    if (!resetN) model_reset();
    e_rden = resetN && !m_flush && !redirectValid && (mq.size() + int'(m_infl) < int'(DEPTH));
    head   = (mq.size() > 0) ? mq[0] : '0;
    obs_rden  = memReadEnable;
    obs_addr  = memAddress;
    obs_valid = instructionValid;
    obs_instr = instruction;
    obs_ipc   = instructionPc;
    chk("memReadEnable", 32'(obs_rden), 32'(e_rden));
    chk("memAddress", 32'(obs_addr), 32'(m_fpc));
    chk("instructionValid", 32'(obs_valid), 32'(mq.size() > 0));
    chk("instruction", 32'(obs_instr), 32'(head[IW+PCW-1:PCW]));
    chk("instructionPc", 32'(obs_ipc), 32'(head[PCW-1:0]));
    if (resetN) begin
      if (redirectValid) begin
        mq.delete();
        m_fpc   = int'(redirectPc);
        m_infl  = 0;
        m_flush = 1;
      end else begin
        if (mq.size() > 0 && instructionReady) void'(mq.pop_front());
        if (m_infl) mq.push_back(m_infl_ent);
        m_infl = e_rden;
        if (e_rden) begin
          m_infl_ent = {mem[m_fpc], PCW'(m_fpc)};
          m_fpc      = (m_fpc + 1) % 16;
        end
        m_flush = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic redirect_to(input logic [PCW-1:0] pc);
    redirectValid = 1'b1;
    redirectPc    = pc;
    step();
    redirectValid = 1'b0;
  endtask

  initial begin
    int nreads;
    logic [PCW-1:0] wrap_seq [4];
    wrap_seq[0] = 4'd14; wrap_seq[1] = 4'd15; wrap_seq[2] = 4'd0; wrap_seq[3] = 4'd1;

    for (int k = 0; k < 16; k++) mem[k] = 16'h1000 + 16'(k);
    memData          = '0;
    resetN           = 1'b0;
    redirectValid    = 1'b0;
    redirectPc       = '0;
    instructionReady = 1'b1;
    model_reset();

    // Reset state.
    step();
    step();

    // Release: reads 0,1,2..., head 0x1000 at pc 0 two cycles later, then 1/cycle.
    resetN = 1'b1;
    step();
    chk("first_read_en", 32'(obs_rden), 32'd1);
    chk("first_read_addr", 32'(obs_addr), 32'd0);
    step();
    chk("head_after_release", 32'(instruction), 32'h1000);
    chk("head_pc_after_release", 32'(instructionPc), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_pc", 32'(obs_ipc), 32'(i));
      chk("stream_valid", 32'(obs_valid), 32'd1);
    end

    // Backpressure: exactly DEPTH reads, then in-order drain.
    redirect_to(4'd0);
    instructionReady = 1'b0;
    nreads = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      nreads += int'(obs_rden);
    end
    chk("hold_read_count", 32'(nreads), 32'(DEPTH));
    instructionReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_pc", 32'(obs_ipc), 32'(i));
    end

    // Redirect to 9 with 3 queued and one in flight.
    redirect_to(4'd0);
    instructionReady = 1'b0;
    for (int i = 0; i < 5; i++) step();
    redirectValid = 1'b1;
    redirectPc    = 4'd9;
    step();
    chk("pre_redirect_valid", 32'(obs_valid), 32'd1);
    redirectValid    = 1'b0;
    instructionReady = 1'b1;
    step();
    chk("flush_empty", 32'(obs_valid), 32'd0);
    chk("flush_no_read", 32'(obs_rden), 32'd0);
    step();
    chk("redirect_read_en", 32'(obs_rden), 32'd1);
    chk("redirect_read_addr", 32'(obs_addr), 32'd9);
    step();
    step();
    chk("redirect_head_pc", 32'(obs_ipc), 32'd9);
    chk("redirect_head_instr", 32'(obs_instr), 32'h1009);

    // PC wrap from 14.
    redirect_to(4'd14);
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 4) chk("wrap_addr", 32'(obs_addr), 32'(wrap_seq[i]));
      if (i >= 2) chk("wrap_ipc", 32'(obs_ipc), 32'(wrap_seq[i-2]));
    end

    // Back-to-back redirects: 5 is never fetched, 2 is.
    redirectValid = 1'b1;
    redirectPc    = 4'd5;
    step();
    chk("redirect1_no_read", 32'(obs_rden), 32'd0);
    redirectPc = 4'd2;
    step();
    chk("redirect2_no_read", 32'(obs_rden), 32'd0);
    redirectValid = 1'b0;
    step();
    chk("double_flush_no_read", 32'(obs_rden), 32'd0);
    step();
    chk("double_redirect_addr", 32'(obs_addr), 32'd2);
    chk("double_redirect_en", 32'(obs_rden), 32'd1);

    // Mid-stream asynchronous reset.
    for (int i = 0; i < 3; i++) step();
    resetN = 1'b0;
    #1;
    chk("async_reset_valid", 32'(instructionValid), 32'd0);
    chk("async_reset_rden", 32'(memReadEnable), 32'd0);
    step();
    resetN = 1'b1;
    step();
    chk("restart_addr", 32'(obs_addr), 32'd0);
    chk("restart_en", 32'(obs_rden), 32'd1);
    step();
    chk("restart_gap_valid", 32'(obs_valid), 32'd0);
    step();
    chk("restart_head_pc", 32'(obs_ipc), 32'd0);
    chk("restart_head_instr", 32'(obs_instr), 32'h1000);

    // Randomized traffic with random memory contents.
    for (int k = 0; k < 16; k++) mem[k] = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      instructionReady = ($urandom_range(0, 3) != 0);
      redirectValid    = ($urandom_range(0, 15) == 0);
      redirectPc       = PCW'($urandom);
      resetN           = ($urandom_range(0, 63) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter PC_WIDTH, default 4, program-counter and memory-address width.
REQ-002 Parameter INSTRUCTION_WIDTH, default 16, instruction word width.
REQ-003 Parameter QUEUE_DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 memAddress  output  PC_WIDTH  instruction-memory read address.
REQ-007 memReadEnable  output  1  read strobe; memData is valid exactly one cycle later.
REQ-008 memData  input  INSTRUCTION_WIDTH  synchronous instruction-memory read data.
REQ-009 redirectValid  input  1  jump or reset from the execute stage; flushes the queue.
REQ-010 redirectPc  input  PC_WIDTH  new fetch address; sampled when redirectValid=1.
REQ-011 instructionValid  output  1  queue head is valid.
REQ-012 instruction  output  INSTRUCTION_WIDTH  queue-head instruction; 0 when the queue is empty.
REQ-013 instructionPc  output  PC_WIDTH  address of the queue-head instruction; 0 when the queue is empty.
REQ-014 instructionReady  input  1  consumer accepts the head when instructionValid=1 in the same cycle.

Function
REQ-015 Block SHALL hold a fetch PC, a QUEUE_DEPTH-entry FIFO of {instruction, pc}, an inFlight flag and a two-state FSM {FETCH, FLUSH}.
REQ-016 In FETCH, memReadEnable SHALL be 1 iff count + inFlight < QUEUE_DEPTH and redirectValid=0.
REQ-017 memAddress SHALL equal the fetch PC; each issued read SHALL increment the fetch PC by 1, modulo 2^PC_WIDTH (wrap from all-ones to 0).
REQ-018 A read issued in cycle N SHALL set inFlight for cycle N+1; in that cycle memData SHALL be pushed with its issuing address, unless it is discarded by a flush.
REQ-019 A pop SHALL occur iff instructionValid and instructionReady are both 1; push and pop in the same cycle SHALL leave count unchanged.
REQ-020 Credit accounting SHALL NOT count a same-cycle pop; the FIFO SHALL never overflow, and a pop from an empty FIFO SHALL be impossible.
REQ-021 When redirectValid=1 in any state, the block SHALL do the following at the next edge: empty the FIFO, set the fetch PC to redirectPc, discard any in-flight return, and enter FLUSH.
REQ-022 redirectValid SHALL take priority over a simultaneous pop, push or issue; a handshake in that cycle counts as consumed, and the queue is still flushed.
REQ-023 In FLUSH, memReadEnable SHALL be 0, the in-flight return SHALL be dropped, and the FSM SHALL go to FETCH the next cycle unless redirectValid=1 again, in which case it stays in FLUSH with the newest redirectPc.
REQ-024 Sustained throughput with instructionReady held at 1 SHALL be one instruction per cycle.
REQ-025 Latency SHALL be 2 cycles from issue to instructionValid: read in cycle N, push at edge N+1, head visible in cycle N+2.

Reset
REQ-026 While resetN=0, the block SHALL hold: fetch PC=0, count=0, FIFO pointers=0, inFlight=0, FSM=FETCH, memReadEnable=0, memAddress=0, instructionValid=0, instruction=0, instructionPc=0.
REQ-027 The first read SHALL issue in the first clock cycle after resetN deasserts, at address 0.
REQ-028 A reset asserted mid-operation SHALL discard all queued and in-flight data immediately, asynchronously.

Structure
REQ-029 The FSM state enum and default widths SHALL live in the shared parameters package alongside the opcode constants.
REQ-030 The FIFO storage SHALL be one sub-module, fetch_fifo (parameterised depth and width, push/pop/count, synchronous flush).

Verification
REQ-031 Release reset with memory word[k]=0x1000+k and ready=1 -> reads at addresses 0,1,2,…; head 0x1000 at pc 0 two cycles after release; then one instruction per cycle.
REQ-032 Hold ready=0 for 10 cycles -> exactly QUEUE_DEPTH=4 reads issued, memReadEnable stays 0; on release, pcs 0,1,2,3 pop in order with no loss.
REQ-033 redirectValid with redirectPc=9 while 3 entries are queued and a read is in flight -> next cycle is empty with no read; the cycle after reads address 9; the next head has pc 9 and no stale data.
REQ-034 With PC_WIDTH=4, fetch from pc 14 -> address sequence 14, 15, 0, 1; instructionPc follows the same sequence.
REQ-035 Redirect in consecutive cycles (pc 5, then pc 2) -> stays in FLUSH; the first fetch is at 2; pc 5 is never read.
REQ-036 Assert resetN=0 mid-stream for 1 cycle -> instructionValid=0 immediately; restart at address 0; no data from before the reset appears.
